// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-tag owners and the memory request bundle.
package data_memory_arbiter_pkg;

    typedef logic [31:0] word;

    typedef enum logic [0:0] {
        NORMAL,
        STEAL
    } arb_state_t;

    typedef enum logic [0:0] {
        OWNER_PIPE,
        OWNER_DBG
    } mem_owner_t;

    typedef struct packed {
        logic       we;
        word        addr;
        word        wdata;
        logic [3:0] be;
    } mem_req_t;

    typedef struct packed {
        logic       vld;
        mem_owner_t owner;
    } read_tag_t;

    localparam mem_req_t MEM_REQ_IDLE = '0;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the pipeline, debug and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_memory_arbiter_if;
    import data_memory_arbiter_pkg::*;

    logic       pipe_req;
    logic       pipe_we;
    word        pipe_addr;
    word        pipe_wdata;
    logic [3:0] pipe_be;
    logic       pipe_stall;

    logic       dbg_req;
    logic       dbg_we;
    word        dbg_addr;
    word        dbg_wdata;
    logic [3:0] dbg_be;
    logic       dbg_ack;
    logic       dbg_rvalid;
    word        dbg_rdata;

    logic       mem_en;
    logic       mem_we;
    word        mem_addr;
    word        mem_wdata;
    logic [3:0] mem_be;
    word        mem_rdata;

    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_be,
        output pipe_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
        output dbg_ack, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata, pipe_be,
        input  pipe_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
        input  dbg_ack, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

endinterface

// File: rtl/data_memory_arbiter_read_tag_pipe.sv
// Read-tag delay line: tags pushed at issue appear at the tail READ_LATENCY cycles later.
// Latency READ_LATENCY; no backpressure, one push per cycle.
module read_tag_pipe
    import data_memory_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  read_tag_t push_tag,
    output read_tag_t tail_tag
);

    read_tag_t [READ_LATENCY-1:0] tag_q;
    read_tag_t [READ_LATENCY-1:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = push_tag;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tail_tag = tag_q[READ_LATENCY-1];

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the data-memory port between stage-4a and debug; zero-cycle issue, debug reads return after READ_LATENCY.
// Pipeline has priority; with ARB_STARVE_EN a starved debug request steals one cycle via pipe_stall.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || READ_LATENCY < 1) begin : g_param_check
        $error("data_memory_arbiter: STARVE_LIMIT and READ_LATENCY must be >= 1");
    end

    mem_req_t  pipe_r;
    mem_req_t  dbg_r;
    mem_req_t  mem_r;
    logic      in_steal;
    logic      pipe_win;
    logic      dbg_win;
    logic      dbg_rvalid;
    read_tag_t push_tag;
    read_tag_t tail_tag;

    assign pipe_r = '{we: bus.pipe_we, addr: bus.pipe_addr, wdata: bus.pipe_wdata, be: bus.pipe_be};
    assign dbg_r  = '{we: bus.dbg_we,  addr: bus.dbg_addr,  wdata: bus.dbg_wdata,  be: bus.dbg_be};

    // A steal cycle ignores the pipeline; otherwise debug only gets the idle cycles.
    always_comb begin
        pipe_win = ~reset & bus.pipe_req & ~in_steal;
        dbg_win  = ~reset & bus.dbg_req & (in_steal | ~bus.pipe_req);
        mem_r    = MEM_REQ_IDLE;
        if (pipe_win) begin
            mem_r = pipe_r;
        end else if (dbg_win) begin
            mem_r = dbg_r;
        end
        push_tag = '{vld: (pipe_win | dbg_win) & ~mem_r.we,
                     owner: (dbg_win ? OWNER_DBG : OWNER_PIPE)};
    end

    assign bus.mem_en    = pipe_win | dbg_win;
    assign bus.mem_we    = mem_r.we;
    assign bus.mem_addr  = mem_r.addr;
    assign bus.mem_wdata = mem_r.wdata;
    assign bus.mem_be    = mem_r.be;
    assign bus.dbg_ack   = dbg_win;

`ifdef ARB_STARVE_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             pipe_stall_q;
    logic             pipe_stall_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= NORMAL;
            wait_cnt_q   <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    always_comb begin
        state_d    = NORMAL;
        wait_cnt_d = wait_cnt_q;
        if (!bus.dbg_req || dbg_win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        case (state_q)
            NORMAL: begin
                if (pipe_win && bus.dbg_req && (wait_cnt_q == CNT_MAX)) begin
                    state_d = STEAL;
                end
            end
            STEAL:   state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
        // Stall is registered so the pipeline sees it exactly in the steal cycle.
        pipe_stall_d = (state_d == STEAL);
    end

    assign in_steal       = (state_q == STEAL);
    assign bus.pipe_stall = pipe_stall_q;
`else
    assign in_steal       = 1'b0;
    assign bus.pipe_stall = 1'b0;
`endif

    read_tag_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_tag_pipe (
        .clock    (clock),
        .reset    (reset),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    // Pipeline read data bypasses the arbiter, so only debug-owned tags matter here.
    assign dbg_rvalid     = ~reset & tail_tag.vld & (tail_tag.owner == OWNER_DBG);
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomised and directed bench for data_memory_arbiter against a behavioural model of the arbitration rules.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 8;
    localparam int READ_LATENCY = 2;
`ifdef ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_memory_arbiter_if bus ();

    data_memory_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  age      = 0;   // cycles the current debug request has waited unacknowledged
    word rd_addr_at [int];
    bit  dbg_rd_at  [int];

    logic obs_ack = 1'b0, obs_rv = 1'b0, obs_stall = 1'b0, obs_en = 1'b0, obs_we = 1'b0;
    word  obs_addr = '0, obs_rdata = '0;

    function automatic word mem_word(word a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_pipe(logic req, logic we, word addr);
        bus.pipe_req   = req;
        bus.pipe_we    = we;
        bus.pipe_addr  = addr;
        bus.pipe_wdata = $urandom;
        bus.pipe_be    = 4'($urandom);
    endtask

    task automatic drive_dbg(logic req, logic we, word addr);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = $urandom;
        bus.dbg_be    = 4'($urandom);
    endtask

    // One clock cycle: return memory data, check outputs against the model, advance the model.
    task automatic step();
        bit steal, p_iss, d_iss, exp_rv;
        steal = 1'b0; p_iss = 1'b0; d_iss = 1'b0; exp_rv = 1'b0;
        @(negedge clock);
        if (rd_addr_at.exists(cyc - READ_LATENCY)) bus.mem_rdata = mem_word(rd_addr_at[cyc - READ_LATENCY]);
        else bus.mem_rdata = $urandom;
        #1;
        if (reset) begin
            check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
            check_eq("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
            check_eq("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        end else begin
            steal  = STARVE_EN && (age == STARVE_LIMIT + 1);
            p_iss  = bus.pipe_req && !steal;
            d_iss  = bus.dbg_req && (steal || !bus.pipe_req);
            exp_rv = dbg_rd_at.exists(cyc - READ_LATENCY);
            check_eq("pipe_stall", 32'(bus.pipe_stall), 32'(steal));
            check_eq("mem_en", 32'(bus.mem_en), 32'(p_iss || d_iss));
            check_eq("mem_we", 32'(bus.mem_we), 32'(p_iss ? bus.pipe_we : (d_iss ? bus.dbg_we : 1'b0)));
            check_eq("dbg_ack", 32'(bus.dbg_ack), 32'(d_iss));
            if (p_iss) begin
                check_eq("mem_addr_pipe", bus.mem_addr, bus.pipe_addr);
                check_eq("mem_wdata_pipe", bus.mem_wdata, bus.pipe_wdata);
                check_eq("mem_be_pipe", 32'(bus.mem_be), 32'(bus.pipe_be));
            end else if (d_iss) begin
                check_eq("mem_addr_dbg", bus.mem_addr, bus.dbg_addr);
                check_eq("mem_wdata_dbg", bus.mem_wdata, bus.dbg_wdata);
                check_eq("mem_be_dbg", 32'(bus.mem_be), 32'(bus.dbg_be));
            end
            check_eq("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(exp_rv));
            if (exp_rv) check_eq("dbg_rdata", bus.dbg_rdata, mem_word(rd_addr_at[cyc - READ_LATENCY]));
        end
        obs_ack = bus.dbg_ack; obs_rv = bus.dbg_rvalid; obs_stall = bus.pipe_stall;
        obs_en = bus.mem_en; obs_we = bus.mem_we; obs_addr = bus.mem_addr; obs_rdata = bus.dbg_rdata;
        @(posedge clock);
        #1;
        if (reset) begin
            age = 0;
            rd_addr_at.delete();
            dbg_rd_at.delete();
        end else begin
            if (bus.dbg_req && !d_iss) age++;
            else age = 0;
            if (p_iss && !bus.pipe_we) rd_addr_at[cyc] = bus.pipe_addr;
            if (d_iss && !bus.dbg_we) begin
                rd_addr_at[cyc] = bus.dbg_addr;
                dbg_rd_at[cyc]  = 1'b1;
            end
        end
        cyc++;
    endtask

    initial begin
        int  stalls, ack_at, reissue, rv_cnt, rv_at, pct;
        logic prev_stall;
        word held_addr, rv_dat;
        logic [4:0] post;

        drive_pipe(1'b0, 1'b0, '0);
        drive_dbg(1'b0, 1'b0, '0);
        bus.mem_rdata = '0;

        // Reset, then idle outputs.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        check_eq("reset_idle", {27'd0, obs_stall, obs_ack, obs_rv, obs_en, obs_we}, 32'd0);

        // Debug read of 0x40 with an idle pipeline.
        drive_dbg(1'b1, 1'b0, 32'h40);
        step();
        check_eq("b_ack_same_cycle", 32'(obs_ack), 32'd1);
        drive_dbg(1'b0, 1'b0, '0);
        step(); step();
        check_eq("b_rvalid", 32'(obs_rv), 32'd1);
        check_eq("b_rdata", obs_rdata, 32'hDEAD_BEEF);

        // Pipe and debug collide for one cycle.
        drive_pipe(1'b1, 1'b1, 32'h80);
        drive_dbg(1'b1, 1'b0, 32'h84);
        step();
        check_eq("c_pipe_wins", obs_addr, 32'h80);
        check_eq("c_no_ack", 32'(obs_ack), 32'd0);
        drive_pipe(1'b0, 1'b0, '0);
        step();
        check_eq("c_ack_next", 32'(obs_ack), 32'd1);
        drive_dbg(1'b0, 1'b0, '0);
        step(); step(); step();

        // Continuous pipeline traffic with a debug write held.
        stalls = 0; ack_at = -1; reissue = 0; held_addr = '0; prev_stall = 1'b0;
        drive_pipe(1'b1, 1'b0, 32'h1000);
        drive_dbg(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 100; i++) begin
            step();
            if (prev_stall && obs_en && obs_addr == held_addr) reissue++;
            if (obs_stall) held_addr = bus.pipe_addr;
            stalls += int'(obs_stall);
            prev_stall = obs_stall;
            if (obs_ack && ack_at < 0) begin
                ack_at = i;
                drive_dbg(1'b0, 1'b0, '0);
            end
            if (!obs_stall) drive_pipe(1'b1, 1'b0, 32'h1000 + word'(4 * (i + 1)));
        end
        check_eq("d_stall_cycles", 32'(stalls), STARVE_EN ? 32'd1 : 32'd0);
        check_eq("d_ack_cycle", 32'(ack_at), STARVE_EN ? 32'(STARVE_LIMIT + 1) : 32'hFFFF_FFFF);
        check_eq("d_reissue", 32'(reissue), STARVE_EN ? 32'd1 : 32'd0);
        drive_pipe(1'b0, 1'b0, '0);
        step();
        drive_dbg(1'b0, 1'b0, '0);
        step(); step(); step();

        // Interleaved pipe 0x10, debug 0x20, pipe 0x30 reads.
        rv_cnt = 0; rv_at = -1; rv_dat = '0;
        for (int i = 0; i < 7; i++) begin
            drive_pipe(i == 0 || i == 2, 1'b0, (i == 0) ? 32'h10 : 32'h30);
            drive_dbg(i == 1, 1'b0, 32'h20);
            step();
            if (obs_rv) begin
                rv_cnt++;
                rv_at  = i;
                rv_dat = obs_rdata;
            end
        end
        check_eq("e_rv_count", 32'(rv_cnt), 32'd1);
        check_eq("e_rv_cycle", 32'(rv_at), 32'(1 + READ_LATENCY));
        check_eq("e_rv_data", rv_dat, mem_word(32'h20));

        // Reset one cycle after a debug read issues.
        rv_cnt = 0; post = '1;
        for (int i = 0; i < 6; i++) begin
            reset = (i == 1);
            drive_dbg(i == 0, 1'b0, 32'h44);
            drive_pipe(1'b0, 1'b0, '0);
            step();
            if (i >= 1 && obs_rv) rv_cnt++;
            if (i == 2) post = {obs_stall, obs_ack, obs_rv, obs_en, obs_we};
        end
        check_eq("f_no_rvalid", 32'(rv_cnt), 32'd0);
        check_eq("f_outputs_zero", 32'(post), 32'd0);

        // Random traffic at increasing pipeline load.
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 40 : ((ph == 1) ? 85 : 100);
            for (int i = 0; i < 1000; i++) begin
                if (!obs_stall)
                    drive_pipe($urandom_range(0, 99) < pct, 1'($urandom_range(0, 1)),
                               word'($urandom_range(0, 63) * 4));
                if (obs_ack || !bus.dbg_req) begin
                    if ($urandom_range(0, 99) < 35)
                        drive_dbg(1'b1, 1'($urandom_range(0, 1)), word'($urandom_range(0, 63) * 4));
                    else
                        drive_dbg(1'b0, 1'b0, '0);
                end
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single data-memory port between the pipeline's stage-4a load/store access and a debug/loader requester. The block sits between the stage-4a request signals and `data_memory_top`. It routes each memory read return to its owner and, when the starvation feature is compiled in, briefly stalls the pipeline so that debug traffic makes progress.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: number of cycles a debug request may wait before the arbiter forces a steal cycle. Legal range is ≥1.
- `READ_LATENCY`, default 2: cycles from issuing a memory read to `mem_rdata` being valid. Legal range is ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pipe_req`  in  1  stage-4a memory access valid.
- `pipe_we`  in  1  1 = store.
- `pipe_addr`  in  32  byte address.
- `pipe_wdata`  in  32  store data.
- `pipe_be`  in  4  byte enables.
- `pipe_stall`  out  1  registered; while high the pipeline holds its stage-4a request stable.
- `dbg_req`  in  1  debug access request; held until acknowledged.
- `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_be`  in  1/32/32/4  debug access fields.
- `dbg_ack`  out  1  one-cycle pulse in the cycle the debug access issues to memory.
- `dbg_rvalid`  out  1  debug read data valid.
- `dbg_rdata`  out  32  debug read data.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/1/32/32/4  memory port.
- `mem_rdata`  in  32  memory read data, valid `READ_LATENCY` cycles after issue.

## Operation
- State machine states:
  - `NORMAL`: the pipeline has fixed priority.
    - If `pipe_req` is high, the pipeline access issues.
    - Otherwise, if `dbg_req` is high, the debug access issues and `dbg_ack`=1.
  - `STEAL`: lasts exactly one cycle. `pipe_stall`=1, `pipe_req` is ignored, and the debug access issues with `dbg_ack`=1. The next state is always `NORMAL`.
- Starvation counter `wait_cnt`:
  - Width is $clog2(STARVE_LIMIT+1).
  - Increments each cycle that `dbg_req` is high and not acknowledged.
  - Saturates at `STARVE_LIMIT`.
  - Clears on `dbg_ack` and on any cycle with `dbg_req` low.
- Entering `STEAL`: when `wait_cnt` reaches `STARVE_LIMIT` in `NORMAL` and the pipeline wins that cycle, the next state is `STEAL`. `pipe_stall` is registered, so it rises exactly at entry to `STEAL`.
- `mem_*` outputs are a combinational mux of the winning request. When nothing issues, `mem_en`=0 and `mem_we`=0.
- Read tags:
  - A `READ_LATENCY`-deep shift register carries {valid, owner} for each issued read. Writes push valid=0.
  - At the tail, owner=debug produces `dbg_rvalid`=1 and `dbg_rdata`=`mem_rdata`.
  - Pipeline read data bypasses the arbiter; owner=pipe produces no output.
- `dbg_req` dropped during `STEAL` is illegal. If it happens, the stall is still taken and no access issues.

## Timing
- Reset values: `pipe_stall`=0, `dbg_ack`=0, `dbg_rvalid`=0, `dbg_rdata`=0, `mem_en`=0, `mem_we`=0; state=`NORMAL`; `wait_cnt`=0; all tags invalid.
- Reset mid-operation discards outstanding debug reads: no `dbg_rvalid` for them.
- Issue latency: 0 cycles from winning arbitration to `mem_*`.
- Debug read return: `dbg_rvalid` rises exactly `READ_LATENCY` cycles after its `dbg_ack`.
- Worst-case debug wait under continuous `pipe_req`: `STARVE_LIMIT`+1 cycles from `dbg_req` rising to `dbg_ack`.
- Back-to-back debug requests are allowed. A new request is sampled the cycle after `dbg_ack`, and `wait_cnt` restarts from 0.
- Pipeline throughput loss is at most one stall cycle per debug access.

## Configuration
- `ARB_STARVE_EN`:
  - Defined: counter and `STEAL` state are present, as above.
  - Undefined: there is no counter and no `STEAL`. `pipe_stall` is tied to 0, and debug accesses issue only on cycles with `pipe_req` low, so unbounded debug wait is permitted.

## Structure
- Shared package:
  - `arb_state_t` enum {`NORMAL`, `STEAL`}.
  - `mem_owner_t` enum {`OWNER_PIPE`, `OWNER_DBG`}.
  - `mem_req_t` packed struct {we, addr, wdata, be}.
  - Reuses the existing `word` type.
- Sub-module `read_tag_pipe`: parameterised by `READ_LATENCY`. Push {valid, owner} in, tail {valid, owner} out, synchronous reset clears all entries.

## Test plan
- Pipe idle; debug read of 0x40 with memory holding 0xDEADBEEF → `dbg_ack` in the same cycle, `dbg_rvalid`/`dbg_rdata`=0xDEADBEEF two cycles later.
- `pipe_req` and `dbg_req` both high for 1 cycle, `STARVE_LIMIT`=8 → pipe access issues, `dbg_ack` the next cycle once `pipe_req` drops.
- Continuous `pipe_req` with `dbg_req` held, `ARB_STARVE_EN` defined → exactly one `pipe_stall` cycle, `dbg_ack` on the 9th cycle after the request, pipeline address reissued and accepted the following cycle.
- Same stimulus with `ARB_STARVE_EN` undefined → `pipe_stall` never asserts and no `dbg_ack` over 100 cycles.
- Interleaved pipe read of 0x10, debug read of 0x20, pipe read of 0x30 → `dbg_rvalid` only for 0x20, aligned to its tag.
- Reset asserted one cycle after a debug read issues → no `dbg_rvalid`; all outputs 0 the cycle after reset.
